// File: rtl/ip_session_initiator.sv
// Initiator for the ip_enable / req_disable / ack / idle session handshake, with wait timeouts.
// Define IP_SESSION_AUTOSTOP_EN to end the active phase automatically after ACTIVE_MAX cycles.
module ip_session_initiator #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned ACTIVE_MAX = 256
) (
  input  logic clk,
  input  logic sync_rst,
  input  logic start,
  input  logic stop,
  input  logic err_clr,
  input  logic idle,
  input  logic ack,
  output logic ip_enable,
  output logic req_disable,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("TIMEOUT must be >= 1");
  end
  if (ACTIVE_MAX < 1) begin : g_active_max_chk
    $error("ACTIVE_MAX must be >= 1");
  end

  typedef enum logic [2:0] {
    StIdle, StEnReq, StWaitEn, StActive, StDisReq, StWaitIdle, StDone, StErr
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            stop_pend_q, stop_pend_d;
  logic            tmo_hit;
  logic            wait_st;
  logic            auto_stop;

  // Hit on the last permitted wait cycle, so each wait lasts at most TIMEOUT cycles.
  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT - 1));
  assign wait_st = (state_q == StWaitEn) || (state_q == StDisReq) || (state_q == StWaitIdle);

`ifdef IP_SESSION_AUTOSTOP_EN
  localparam int unsigned AW = $clog2(ACTIVE_MAX + 1);

  logic [AW-1:0] act_cnt_q, act_cnt_d;

  // Held at zero outside the active phase, so it starts from zero on every entry.
  assign act_cnt_d = (state_q == StActive) ? act_cnt_q + AW'(1) : '0;
  assign auto_stop = (state_q == StActive) && (act_cnt_q == AW'(ACTIVE_MAX - 1));

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      act_cnt_q <= '0;
    end else begin
      act_cnt_q <= act_cnt_d;
    end
  end
`else
  assign auto_stop = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    unique case (state_q)
      StIdle: begin
        stop_pend_d = 1'b0;
        if (start && idle) state_d = StEnReq;
      end
      StEnReq: begin
        if (stop) stop_pend_d = 1'b1;
        state_d = StWaitEn;
      end
      StWaitEn: begin
        if (stop) stop_pend_d = 1'b1;
        if (!idle)        state_d = StActive;
        else if (tmo_hit) state_d = StErr;
      end
      StActive: begin
        // A stop requested during enable is honoured after exactly one active cycle.
        stop_pend_d = 1'b0;
        if (stop || stop_pend_q || auto_stop) state_d = StDisReq;
      end
      StDisReq: begin
        if (ack)          state_d = StWaitIdle;
        else if (tmo_hit) state_d = StErr;
      end
      StWaitIdle: begin
        if (idle)         state_d = StDone;
        else if (tmo_hit) state_d = StErr;
      end
      StDone:  state_d = StIdle;
      StErr: begin
        if (err_clr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (wait_st) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign ip_enable   = (state_q == StEnReq);
  assign req_disable = (state_q == StDisReq);
  assign done        = (state_q == StDone);
  assign err         = (state_q == StErr);
  assign busy        = (state_q != StIdle) && (state_q != StErr);

endmodule

// File: tb/tb_ip_session_initiator.sv
// Directed self-checking bench for ip_session_initiator with a registered responder model.
// Output vectors are printed as {ip_enable, req_disable, busy, done, err}.
module tb_ip_session_initiator;

  logic clk = 1'b0;
  logic sync_rst, start, stop, err_clr, idle, ack;
  logic ip_enable, req_disable, busy, done, err;
  logic [4:0] outs;
  logic [4:0] exp;

  // Responder model controls
  logic idle_q, ack_q;
  logic hold_idle, hold_low, mute_ack, force_ack;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ip_session_initiator #(
    .TIMEOUT   (8),
    .ACTIVE_MAX(4)
  ) dut (
    .clk        (clk),
    .sync_rst   (sync_rst),
    .start      (start),
    .stop       (stop),
    .err_clr    (err_clr),
    .idle       (idle),
    .ack        (ack),
    .ip_enable  (ip_enable),
    .req_disable(req_disable),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  assign outs = {ip_enable, req_disable, busy, done, err};
  assign idle = hold_idle | (idle_q & ~hold_low);
  assign ack  = ack_q | force_ack;

  // Responder: drops idle after ip_enable, acks one cycle after req_disable, idle after ack.
  always @(posedge clk) begin
    if (sync_rst) begin
      idle_q <= 1'b1;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= req_disable & ~ack_q & ~mute_ack;
      if (ip_enable)  idle_q <= 1'b0;
      else if (ack_q) idle_q <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sync_rst  = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    err_clr   = 1'b0;
    hold_idle = 1'b0;
    hold_low  = 1'b0;
    mute_ack  = 1'b0;
    force_ack = 1'b0;
    step();
    step();
    sync_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (outs !== 5'b00000) begin
      nerr++;
      $display("FAIL reset_initial: got %b want %b", outs, 5'b00000);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    sync_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      nvec++;
      if (outs !== 5'b00000) begin
        nerr++;
        $display("FAIL reset_mid_cycle%0d: got %b want %b", i, outs, 5'b00000);
      end
    end
    sync_rst = 1'b0;
    start    = 1'b1;
    step();
    start = 1'b0;
    nvec++;
    if (outs !== 5'b10100) begin
      nerr++;
      $display("FAIL reset_restart: got %b want %b", outs, 5'b10100);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      exp = (c == 1)  ? 5'b10100 :
            (c <= 10) ? 5'b00100 :
            (c <= 12) ? 5'b01100 :
            (c == 13) ? 5'b00100 :
            (c == 14) ? 5'b00110 : 5'b00000;
      nvec++;
      if (outs !== exp) begin
        nerr++;
        $display("FAIL nominal cycle %0d: got %b want %b", c, outs, exp);
      end
      if (c == 10) stop = 1'b1;
      step();
      stop = 1'b0;
    end
  endtask

  task automatic test_early_stop();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      exp = (c == 1) ? 5'b10100 :
            (c <= 3) ? 5'b00100 :
            (c <= 5) ? 5'b01100 :
            (c == 6) ? 5'b00100 :
            (c == 7) ? 5'b00110 : 5'b00000;
      nvec++;
      if (outs !== exp) begin
        nerr++;
        $display("FAIL early_stop cycle %0d: got %b want %b", c, outs, exp);
      end
      if (c == 1) stop = 1'b1;
      step();
      stop = 1'b0;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    hold_idle = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      exp = (c == 1)  ? 5'b10100 :
            (c <= 9)  ? 5'b00100 :
            (c <= 11) ? 5'b00001 :
            (c == 12) ? 5'b00000 : 5'b10100;
      nvec++;
      if (outs !== exp) begin
        nerr++;
        $display("FAIL timeout cycle %0d: got %b want %b", c, outs, exp);
      end
      err_clr = (c == 11);
      start   = (c == 12);
      step();
      err_clr = 1'b0;
      start   = 1'b0;
    end
  endtask

  task automatic test_ack_timeout();
    do_reset();
    mute_ack = 1'b1;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      exp = (c == 1)  ? 5'b10100 :
            (c <= 3)  ? 5'b00100 :
            (c <= 11) ? 5'b01100 : 5'b00001;
      nvec++;
      if (outs !== exp) begin
        nerr++;
        $display("FAIL ack_timeout cycle %0d: got %b want %b", c, outs, exp);
      end
      if (c == 3) stop = 1'b1;
      step();
      stop = 1'b0;
    end
  endtask

  task automatic test_ignored();
    do_reset();
    stop    = 1'b1;
    err_clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      nvec++;
      if (outs !== 5'b00000) begin
        nerr++;
        $display("FAIL ignored_stop_idle %0d: got %b want %b", i, outs, 5'b00000);
      end
    end
    stop     = 1'b0;
    err_clr  = 1'b0;
    hold_low = 1'b1;
    start    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      nvec++;
      if (outs !== 5'b00000) begin
        nerr++;
        $display("FAIL ignored_start_busy %0d: got %b want %b", i, outs, 5'b00000);
      end
    end
    start    = 1'b0;
    hold_low = 1'b0;
    step();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      exp = (c == 1) ? 5'b10100 : 5'b00100;
      nvec++;
      if (outs !== exp) begin
        nerr++;
        $display("FAIL start_stop_together cycle %0d: got %b want %b", c, outs, exp);
      end
      step();
    end
  endtask

  task automatic test_autostop();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef IP_SESSION_AUTOSTOP_EN
    for (int c = 1; c <= 11; c++) begin
      exp = (c == 1)  ? 5'b10100 :
            (c <= 6)  ? 5'b00100 :
            (c <= 8)  ? 5'b01100 :
            (c == 9)  ? 5'b00100 :
            (c == 10) ? 5'b00110 : 5'b00000;
      nvec++;
      if (outs !== exp) begin
        nerr++;
        $display("FAIL autostop cycle %0d: got %b want %b", c, outs, exp);
      end
      step();
    end
`else
    begin
      int seen_dis;
      seen_dis = 0;
      for (int c = 1; c <= 1000; c++) begin
        if (req_disable !== 1'b0) seen_dis++;
        step();
      end
      nvec++;
      if (seen_dis != 0) begin
        nerr++;
        $display("FAIL no_autostop: got %0d req_disable cycles want 0", seen_dis);
      end
      nvec++;
      if (outs !== 5'b00100) begin
        nerr++;
        $display("FAIL no_autostop_busy: got %b want %b", outs, 5'b00100);
      end
    end
`endif
  endtask

  task automatic test_mid_reset();
    do_reset();
    mute_ack = 1'b1;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    nvec++;
    if (outs !== 5'b01100) begin
      nerr++;
      $display("FAIL mid_reset_pre: got %b want %b", outs, 5'b01100);
    end
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    nvec++;
    if (outs !== 5'b00000) begin
      nerr++;
      $display("FAIL mid_reset_post: got %b want %b", outs, 5'b00000);
    end
    mute_ack  = 1'b0;
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (outs !== 5'b00000) begin
        nerr++;
        $display("FAIL mid_reset_late_ack %0d: got %b want %b", i, outs, 5'b00000);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_early_stop();
    test_timeout();
    test_ack_timeout();
    test_ignored();
    test_autostop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
